// File: rtl/router_xy_rr.sv
// router_xy_rr
// ------------
// Five-port 2D-mesh XY router node. Each input port has a small FIFO. Each
// output port has a round-robin arbiter and a registered output stage with
// valid/ready handshake. Packets are a single flit, and the destination
// coordinates sit in the top bits of the flit. A blocked output stalls only
// the inputs whose head flit wants that output.
//
// Port numbering for every 5-bit vector and for every WD-wide slice:
//   0 local, 1 east (+X), 2 west (-X), 3 north (+Y), 4 south (-Y)
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   in_valid   per-input flit present
//   in_data    per-input flit, port p at [p*WD +: WD]
//   in_ready   per-input FIFO has space (forced low while in reset)
//   out_valid  per-output register holds a flit
//   out_data   per-output flit, port p at [p*WD +: WD]
//   out_ready  per-output downstream accepts this cycle

module router_xy_rr #(
    parameter int WD    = 40,
    parameter int CW    = 2,
    parameter int DEPTH = 4,
    parameter int CUR_X = 0,
    parameter int CUR_Y = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      in_valid,
    input  logic [5*WD-1:0] in_data,
    output logic [4:0]      in_ready,
    output logic [4:0]      out_valid,
    output logic [5*WD-1:0] out_data,
    input  logic [4:0]      out_ready
);

    localparam int NP = 5;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] MY_X = CW'(CUR_X);
    localparam logic [CW-1:0] MY_Y = CW'(CUR_Y);

    // Per-input FIFO state
    logic [WD-1:0] memQ [NP][DEPTH];
    logic [AW-1:0] rdPtrQ [NP];
    logic [AW-1:0] rdPtrD [NP];
    logic [AW-1:0] wrPtrQ [NP];
    logic [AW-1:0] wrPtrD [NP];
    logic [AW:0]   countQ [NP];
    logic [AW:0]   countD [NP];

    // Per-output arbiter pointer and output register
    logic [2:0]    rrPtrQ [NP];
    logic [2:0]    rrPtrD [NP];
    logic [NP-1:0] outValidQ;
    logic [NP-1:0] outValidD;
    logic [WD-1:0] outDataQ [NP];
    logic [WD-1:0] outDataD [NP];

    // Routing and arbitration results
    logic [WD-1:0] headFlit [NP];
    logic [NP-1:0] reqForOut [NP];
    logic [NP-1:0] grantValid;
    logic [2:0]    grantIdx [NP];
    logic [NP-1:0] pushVec;
    logic [NP-1:0] popVec;

    // (a + b) mod 5 for a, b in 0..4
    function automatic logic [2:0] modAdd(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'd5) begin
            s = s - 4'd5;
        end
        return s[2:0];
    endfunction

    // XY dimension-order routing: resolve X first, then Y, else deliver locally.
    // The coordinate comparisons are unsigned.
    function automatic logic [2:0] routeOf(input logic [WD-1:0] f);
        logic [CW-1:0] dx;
        logic [CW-1:0] dy;
        logic [2:0]    port;
        dx = f[WD-1 -: CW];
        dy = f[WD-1-CW -: CW];
        if (dx > MY_X) begin
            port = 3'd1;
        end else if (dx < MY_X) begin
            port = 3'd2;
        end else if (dy > MY_Y) begin
            port = 3'd3;
        end else if (dy < MY_Y) begin
            port = 3'd4;
        end else begin
            port = 3'd0;
        end
        return port;
    endfunction

    // Ready is computed from the registered count only. A full FIFO therefore
    // refuses a write even in a cycle where its head is being popped.
    always_comb begin
        in_ready = '0;
        pushVec  = '0;
        for (int i = 0; i < NP; i++) begin
            in_ready[i] = rst_n && (countQ[i] != FULL);
            pushVec[i]  = in_valid[i] && in_ready[i];
        end
    end

    // Head flits are read straight from storage. Only non-empty FIFOs raise a request.
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            reqForOut[o] = '0;
        end
        for (int i = 0; i < NP; i++) begin
            headFlit[i] = memQ[i][rdPtrQ[i]];
            if (countQ[i] != '0) begin
                reqForOut[routeOf(headFlit[i])][i] = 1'b1;
            end
        end
    end

    // Per-output round robin: scan requesters starting at the pointer.
    // An output only grants when its register is empty or is draining this
    // cycle. Each input targets exactly one output, so each input pops at
    // most once per cycle.
    always_comb begin
        grantValid = '0;
        popVec     = '0;
        for (int o = 0; o < NP; o++) begin
            grantIdx[o] = '0;
            if (!outValidQ[o] || out_ready[o]) begin
                for (int k = 0; k < NP; k++) begin
                    if (!grantValid[o] && reqForOut[o][modAdd(rrPtrQ[o], 3'(k))]) begin
                        grantValid[o] = 1'b1;
                        grantIdx[o]   = modAdd(rrPtrQ[o], 3'(k));
                    end
                end
            end
        end
        for (int o = 0; o < NP; o++) begin
            if (grantValid[o]) begin
                popVec[grantIdx[o]] = 1'b1;
            end
        end
    end

    // Next-state logic. DEPTH is a power of two, so the pointers wrap naturally.
    // The output register holds its data while stalled. When it drains with no
    // new grant, only valid drops and the data keeps its last value.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            rdPtrD[i] = rdPtrQ[i] + AW'(popVec[i]);
            wrPtrD[i] = wrPtrQ[i] + AW'(pushVec[i]);
            unique case ({pushVec[i], popVec[i]})
                2'b10:   countD[i] = countQ[i] + 1'b1;
                2'b01:   countD[i] = countQ[i] - 1'b1;
                default: countD[i] = countQ[i];
            endcase
        end
        for (int o = 0; o < NP; o++) begin
            outValidD[o] = outValidQ[o];
            outDataD[o]  = outDataQ[o];
            rrPtrD[o]    = rrPtrQ[o];
            if (grantValid[o]) begin
                outValidD[o] = 1'b1;
                outDataD[o]  = headFlit[grantIdx[o]];
                rrPtrD[o]    = modAdd(grantIdx[o], 3'd1);
            end else if (out_ready[o]) begin
                outValidD[o] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValidQ <= '0;
            for (int i = 0; i < NP; i++) begin
                rdPtrQ[i]   <= '0;
                wrPtrQ[i]   <= '0;
                countQ[i]   <= '0;
                rrPtrQ[i]   <= '0;
                outDataQ[i] <= '0;
            end
        end else begin
            outValidQ <= outValidD;
            for (int i = 0; i < NP; i++) begin
                rdPtrQ[i]   <= rdPtrD[i];
                wrPtrQ[i]   <= wrPtrD[i];
                countQ[i]   <= countD[i];
                rrPtrQ[i]   <= rrPtrD[i];
                outDataQ[i] <= outDataD[i];
            end
        end
    end

    // Storage needs no reset. The counts gate every read, and pushVec is low during reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (pushVec[i]) begin
                memQ[i][wrPtrQ[i]] <= in_data[i*WD +: WD];
            end
        end
    end

    always_comb begin
        out_valid = outValidQ;
        out_data  = '0;
        for (int o = 0; o < NP; o++) begin
            out_data[o*WD +: WD] = outDataQ[o];
        end
    end

endmodule

// File: tb/tb_router_xy_rr.sv
// tb_router_xy_rr
// ---------------
// Directed bench for router_xy_rr with the node placed at (1,1).
// Stimulus tasks push each flit's expected arrival onto a per-output queue.
// A negedge monitor pops a queue entry and compares it whenever an output
// completes a valid/ready handshake. Direct checks cover reset values,
// latency, ready behaviour and stability while stalled.

module tb_router_xy_rr;

    localparam int WD    = 40;
    localparam int CW    = 2;
    localparam int DEPTH = 4;
    localparam int NP    = 5;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic [4:0]      inValid  = '0;
    logic [5*WD-1:0] inData   = '0;
    logic [4:0]      inReady;
    logic [4:0]      outValid;
    logic [5*WD-1:0] outData;
    logic [4:0]      outReady = 5'h1f;

    int assertCount = 0;
    int failCount   = 0;
    int hsCount [NP] = '{default: 0};
    logic [WD-1:0] expQ [NP][$];

    router_xy_rr #(
        .WD(WD), .CW(CW), .DEPTH(DEPTH), .CUR_X(1), .CUR_Y(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(inValid),
        .in_data(inData),
        .in_ready(inReady),
        .out_valid(outValid),
        .out_data(outData),
        .out_ready(outReady)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Hard stop in case something wedges the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [WD-1:0] mkFlit(input logic [1:0] dx, input logic [1:0] dy,
                                             input logic [35:0] pl);
        return {dx, dy, pl};
    endfunction

    function automatic int totalPending();
        int n;
        n = 0;
        for (int o = 0; o < NP; o++) begin
            n += expQ[o].size();
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one input slot. If expOut >= 0, also record where the flit should appear.
    task automatic applyStimulus(input int port, input logic [WD-1:0] flit, input int expOut);
        inValid[port]         = 1'b1;
        inData[port*WD +: WD] = flit;
        if (expOut >= 0) begin
            expQ[expOut].push_back(flit);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        inValid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int o = 0; o < NP; o++) begin
            expQ[o].delete();
        end
        #1;
    endtask

    // Scoreboard monitor: a handshake seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int o = 0; o < NP; o++) begin
                if (outValid[o] && outReady[o]) begin
                    hsCount[o]++;
                    if (expQ[o].size() == 0) begin
                        assertCount++;
                        failCount++;
                        $display("[TB] FAIL unexpected_flit_out%0d: got 0x%0h, expected none",
                                 o, outData[o*WD +: WD]);
                    end else begin
                        checkOutput($sformatf("scoreboard_out%0d", o),
                                    64'(outData[o*WD +: WD]), 64'(expQ[o].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        int accepted;
        int hs0;
        logic [WD-1:0] firstFlit;

        // Reset state
        rst_n    = 1'b0;
        outReady = 5'h1f;
        tick();
        tick();
        checkOutput("reset_in_ready", 64'(inReady), 64'd0);
        checkOutput("reset_out_valid", 64'(outValid), 64'd0);
        for (int o = 0; o < NP; o++) begin
            checkOutput($sformatf("reset_out_data%0d", o), 64'(outData[o*WD +: WD]), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", 64'(inReady), 64'h1f);

        // Single flit: local -> east, visible one edge after acceptance
        $display("[TB] single flit latency");
        applyStimulus(0, mkFlit(2'd2, 2'd1, 36'hA_0001), 1);
        tick();
        inValid = '0;
        checkOutput("lat_before", 64'(outValid), 64'd0);
        tick();
        checkOutput("lat_out_valid", 64'(outValid), 64'b00010);
        checkOutput("lat_out_data", 64'(outData[1*WD +: WD]), 64'(mkFlit(2'd2, 2'd1, 36'hA_0001)));
        tick();
        tick();

        // XY ordering: (1,0)->south, (1,1)->local, (0,3)->west first
        $display("[TB] XY route order");
        applyStimulus(2, mkFlit(2'd1, 2'd0, 36'hA_0102), 4);
        applyStimulus(3, mkFlit(2'd1, 2'd1, 36'hA_0103), 0);
        applyStimulus(0, mkFlit(2'd0, 2'd3, 36'hA_0104), 2);
        tick();
        inValid = '0;
        tick();
        checkOutput("xy_out_valid", 64'(outValid), 64'b10101);
        checkOutput("xy_south", 64'(outData[4*WD +: WD]), 64'(mkFlit(2'd1, 2'd0, 36'hA_0102)));
        checkOutput("xy_local", 64'(outData[0*WD +: WD]), 64'(mkFlit(2'd1, 2'd1, 36'hA_0103)));
        checkOutput("xy_west", 64'(outData[2*WD +: WD]), 64'(mkFlit(2'd0, 2'd3, 36'hA_0104)));
        tick();
        tick();

        // Five heads with distinct outputs all advance together
        $display("[TB] parallel distinct outputs");
        applyStimulus(0, mkFlit(2'd2, 2'd1, 36'hA_0200), 1);
        applyStimulus(1, mkFlit(2'd0, 2'd1, 36'hA_0201), 2);
        applyStimulus(2, mkFlit(2'd1, 2'd2, 36'hA_0202), 3);
        applyStimulus(3, mkFlit(2'd1, 2'd0, 36'hA_0203), 4);
        applyStimulus(4, mkFlit(2'd1, 2'd1, 36'hA_0204), 0);
        tick();
        inValid = '0;
        tick();
        checkOutput("par_out_valid", 64'(outValid), 64'h1f);
        tick();
        tick();
        checkOutput("par_drained", 64'(totalPending()), 64'd0);

        // Round robin: the first flit (input 1) is captured while local is
        // stalled. Pointer then sits at 2, so the order is 1,2,3,4,1,2,...
        $display("[TB] round robin on local output");
        doReset();
        outReady = 5'b11110;
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 4; i++) begin
                applyStimulus(i, mkFlit(2'd1, 2'd1, 36'(i * 16 + r)), 0);
            end
            tick();
        end
        inValid = '0;
        checkOutput("rr_held_valid", 64'(outValid[0]), 64'd1);
        checkOutput("rr_held_data", 64'(outData[0*WD +: WD]), 64'(mkFlit(2'd1, 2'd1, 36'd16)));
        tick();
        checkOutput("rr_held_stable", 64'(outData[0*WD +: WD]), 64'(mkFlit(2'd1, 2'd1, 36'd16)));
        hs0      = hsCount[0];
        outReady = 5'h1f;
        repeat (12) tick();
        checkOutput("rr_12_in_12", 64'(hsCount[0] - hs0), 64'd12);
        checkOutput("rr_drained", 64'(expQ[0].size()), 64'd0);
        checkOutput("rr_idle", 64'(outValid), 64'd0);

        // Backpressure: DEPTH+1 flits fit (DEPTH in the FIFO, one in the output register)
        $display("[TB] backpressure and full FIFO");
        doReset();
        outReady  = 5'b11110;
        accepted  = 0;
        firstFlit = mkFlit(2'd1, 2'd1, 36'hB00);
        for (int c = 0; c < 10; c++) begin
            if (inReady[1]) begin
                applyStimulus(1, mkFlit(2'd1, 2'd1, 36'hB00 + 36'(accepted)), 0);
                accepted++;
            end else begin
                // Offered while not ready: must never be stored
                applyStimulus(1, mkFlit(2'd1, 2'd1, 36'hDEAD), -1);
            end
            tick();
        end
        checkOutput("bp_accepted", 64'(accepted), 64'(DEPTH + 1));
        checkOutput("bp_ready_low", 64'(inReady[1]), 64'd0);
        checkOutput("bp_out_valid", 64'(outValid[0]), 64'd1);
        checkOutput("bp_data_stable", 64'(outData[0*WD +: WD]), 64'(firstFlit));
        // Release with the junk flit still offered. The full FIFO is popped
        // on this edge but still refuses the write.
        outReady = 5'h1f;
        tick();
        inValid = '0;
        checkOutput("bp_ready_rises", 64'(inReady[1]), 64'd1);
        repeat (8) tick();
        checkOutput("bp_drained", 64'(expQ[0].size()), 64'd0);

        // Reset mid-traffic with flits buffered and stalled in output registers
        $display("[TB] reset mid-traffic");
        doReset();
        outReady = 5'b00000;
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1, mkFlit(2'd1, 2'd1, 36'hC00 + 36'(r)), -1);
            applyStimulus(0, mkFlit(2'd2, 2'd1, 36'hC10 + 36'(r)), -1);
            tick();
        end
        inValid = '0;
        checkOutput("mid_busy", 64'(outValid), 64'b00011);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_in_ready", 64'(inReady), 64'd0);
        tick();
        checkOutput("mid_reset_out_valid", 64'(outValid), 64'd0);
        rst_n    = 1'b1;
        outReady = 5'h1f;
        #1;
        checkOutput("mid_ready_after", 64'(inReady), 64'h1f);
        repeat (5) tick();
        checkOutput("mid_no_stale", 64'(outValid), 64'd0);
        applyStimulus(2, mkFlit(2'd1, 2'd1, 36'hE01), 0);
        tick();
        inValid = '0;
        tick();
        checkOutput("mid_fresh_valid", 64'(outValid), 64'b00001);
        tick();
        tick();

        checkOutput("all_drained", 64'(totalPending()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/router_xy_rr.md
Name: router_xy_rr

Overview:
- Parametrised successor to the 3-port mesh router: a 5-port 2D-mesh XY router with per-input FIFOs, per-output round-robin arbitration and per-output valid/ready backpressure.
- Replaces the global stall and fail/retry scheme: a blocked output stalls only the flits that want that output.
- Single-flit packets, one instance per mesh node; CUR_X/CUR_Y set the node position.

Parameters:
- WD, 40, flit width in bits.
- CW, 2, coordinate field width.
- DEPTH, 4, per-input FIFO depth; power of 2, >=2.
- CUR_X, 0, this node's X coordinate.
- CUR_Y, 0, this node's Y coordinate.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  5  per input port p: flit present. Ports: 0 local, 1 east(+X), 2 west(-X), 3 north(+Y), 4 south(-Y).
- in_data  in  5*WD  flit for port p at [p*WD +: WD].
- in_ready  out  5  input p can accept a flit this cycle.
- out_valid  out  5  output p holds a flit.
- out_data  out  5*WD  flit on output p at [p*WD +: WD].
- out_ready  in  5  downstream accepts output p this cycle.

Behaviour:
- Flit fields: dest_x = flit[WD-1 -: CW], dest_y = flit[WD-1-CW -: CW]. The rest is payload. All-zero flits are legal data; validity is carried only by the valid signals.
- Reset (rst_n low at posedge):
  - all FIFOs emptied; out_valid = 0; out_data = 0; all RR pointers = 0.
  - in_ready = 0 while rst_n is low.
- Input acceptance:
  - in_ready[p] = (count[p] != DEPTH), from registered count.
  - Write occurs when in_valid[p] && in_ready[p].
  - A full FIFO refuses writes even if it is popped the same cycle.
  - in_valid while in_ready = 0 is ignored; the flit is not stored.
- FIFO:
  - Registered storage with binary rd/wr pointers that wrap modulo DEPTH, plus a count register.
  - Head flit is read combinationally from storage.
  - No empty bypass.
  - Simultaneous push and pop leaves count unchanged.
- Route computation (combinational on each non-empty head), in order:
  - dest_x > CUR_X -> east
  - dest_x < CUR_X -> west
  - dest_y > CUR_Y -> north
  - dest_y < CUR_Y -> south
  - otherwise -> local.
  - Comparisons are unsigned. U-turns are not filtered.
- Arbitration, per output o:
  - Request set = inputs whose head routes to o.
  - Output o may load when !out_valid[o] || out_ready[o].
  - If it may load and requests exist, grant the first requester scanning from ptr[o] upward, mod 5.
  - On grant to input i: ptr[o] <= (i+1) mod 5, the head of input i is popped, and out_data[o] <= head.
  - With no grant, ptr[o] is unchanged.
  - Each input requests exactly one output, so at most one pop per input per cycle.
- Output register:
  - out_valid[o] / out_data[o] are registered.
  - While out_valid && !out_ready, data is held stable.
  - On out_ready with no new grant, out_valid <= 0 and out_data holds its last value.
  - On out_ready with a grant, the register is reloaded back-to-back with no bubble.
- Latency: a flit accepted at edge k, into an empty FIFO with output o free and no competitor, has out_valid[o] = 1 after edge k+1.
- Throughput: one flit per output per cycle. Five distinct-destination heads all advance in the same cycle.
- Ordering: FIFO order per input is preserved. No ordering guarantee across inputs.
- Blocking: a blocked head blocks only its own FIFO (head-of-line). Other inputs continue.
- Reset mid-operation: all in-flight and buffered flits are discarded, and out_valid drops on that edge.

Test Plan:
- Reset then single flit: CUR=(1,1), flit dest (2,1) on local in_valid one cycle -> out_valid[1] = 1 one edge after acceptance, out_data[1] equals the flit, other out_valid = 0.
- XY order: CUR=(1,1), dest (1,0) on west input -> south (port 4). Dest (1,1) -> local (port 0). Dest (0,3) -> west first (port 2).
- Round robin: inputs 1..4 each hold 3 flits all to local, out_ready = 1 -> local grants in sequence 1,2,3,4,1,2,3,4,...; 12 flits in 12 consecutive cycles, none lost, per-input order preserved.
- Backpressure/full: out_ready[0] = 0, stream to local from input 1 -> out_data[0] stable, in_ready[1] falls after DEPTH+1 accepted flits. Release out_ready -> all DEPTH+1 flits drain in order, in_ready[1] rises one edge after the first pop.
- Parallel non-blocking: 5 heads, each targeting a distinct output -> all five out_valid = 1 after the same edge.
- Reset mid-traffic: rst_n low for one edge with FIFOs half full -> out_valid = 0, in_ready = 0 during reset, in_ready = 1 afterwards, no stale flit ever emerges.
